shift_arbiter: RTL
==================

# shift_arbiter

Shares one combinational 32-bit barrel shifter (`Dir`/`Amt`/`D_in` in, separate left/right result buses out) between two requesters. Each requester issues a shift command over a valid/ready handshake. The block grants requesters round-robin, sequences the operand onto the shifter, registers the direction-selected result, and returns it on a per-requester valid/ready response channel. It sits between the two execution-side clients and the shifter instance, and owns all shifter inputs.

## Interface
Parameters:
- `WIDTH`, 32: data width.
- `AMT_W`, 5: shift-amount width; must equal log2(`WIDTH`).

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst_n`  in  1  reset, asynchronous assert, active-low.
- `Req0_valid` / `Req1_valid`  in  1  request present.
- `Req0_ready` / `Req1_ready`  out  1  request accepted this cycle when valid&ready.
- `Req0_dir` / `Req1_dir`  in  1  1 = left, 0 = right.
- `Req0_amt` / `Req1_amt`  in  AMT_W  shift amount.
- `Req0_data` / `Req1_data`  in  WIDTH  operand.
- `Rsp0_valid` / `Rsp1_valid`  out  1  result present.
- `Rsp0_ready` / `Rsp1_ready`  in  1  result consumed when valid&ready.
- `Rsp0_data` / `Rsp1_data`  out  WIDTH  shifted result.
- `Sh_dir`  out  1  to shifter direction.
- `Sh_amt`  out  AMT_W  to shifter amount.
- `Sh_data`  out  WIDTH  to shifter operand.
- `Sh_left` / `Sh_right`  in  WIDTH  shifter results, combinational from `Sh_*`.
- `Busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Arbitrate among asserted `ReqN_valid`.
  - If only one is valid, it wins.
  - If both are valid, the requester other than `last_grant` wins.
  - `ReqN_ready` = (state==IDLE) & winner==N. It is combinational and may depend on both valids.
  - On handshake: capture dir/amt/data and grant id into registers, set `last_grant` = grant id, go to ISSUE.
- ISSUE:
  - Drive `Sh_dir`/`Sh_amt`/`Sh_data` from the captured registers.
  - At the edge, register `Sh_left` when dir=1, else `Sh_right`, into the result register. Go to RESP.
- RESP:
  - `RspN_valid`=1 for the granted N only. The other response valid stays 0.
  - `RspN_data` = result register, held stable until the handshake.
  - On `RspN_ready`, go to IDLE.
- Outside ISSUE, `Sh_amt`=0 and `Sh_data`=0, which minimises toggling. `Sh_dir` holds its last value.
- `RspN_data` for the non-granted requester reads 0.
- Amount 0 returns the operand unchanged. Amount WIDTH-1 shifts logically, filling with zeros. No rotation and no sign extension.
- `ReqN_valid` deasserting before its handshake is legal. Nothing is captured in that case.
- `Rsp_ready` asserted while not valid is ignored.

## Timing
- Reset (`Rst_n`=0, immediate):
  - State = IDLE.
  - `last_grant` = 1, so Req0 wins the first contention.
  - All `ReqN_ready`, `RspN_valid`, `Busy` = 0. All `RspN_data`, `Sh_amt`, `Sh_data`, `Sh_dir` = 0. Captured registers = 0.
- While `Rst_n`=0, ready stays 0 even with `ReqN_valid`=1.
- Latency, with the request handshake in cycle 0:
  - Cycle 1 is ISSUE (`Busy`=1).
  - Cycle 2 has `RspN_valid`=1.
- If `RspN_ready`=1 in cycle 2, cycle 3 is IDLE and can accept the next request. Peak throughput is 1 operation per 3 cycles.
- Response backpressure holds the FSM in RESP indefinitely. No request is accepted meanwhile (both `ReqN_ready`=0).
- `last_grant` updates only on a request handshake, never on a response.
- Reset mid-operation (ISSUE or RESP) aborts the operation. The pending response is dropped and never presented. After deassertion, behaviour is identical to power-up.
- A response handshake and a new request do not overlap in the same cycle. Requests are accepted only in IDLE.

## Test plan
- Reset: hold `Rst_n`=0 with both `ReqN_valid`=1 -> all outputs 0, `Busy`=0, no ready asserted. After release, the first grant goes to Req0.
- Req0 left, data 0x0000_00F1, amt 4, `Rsp0_ready`=1 -> `Req0_ready` in cycle 0; `Sh_amt`=4 in cycle 1 only; `Rsp0_valid`=1 with `Rsp0_data`=0x0000_0F10 in cycle 2; `Rsp1_valid` stays 0.
- Req1 right, 0x8000_0000, amt 31 -> `Rsp1_data`=0x0000_0001. Then amt 0 with 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Both valid continuously with responses always ready -> grants alternate 0,1,0,1. Each operation takes exactly 3 cycles and each result matches its requester's operand.
- `Rsp1_ready`=0 for 5 cycles while Req0 is valid -> `Rsp1_valid` and `Rsp1_data` stay stable. `Req0_ready`=0 throughout. Req0 is accepted on the cycle after the `Rsp1` handshake.
- Assert `Rst_n`=0 during RESP -> `Rsp0_valid` drops immediately and the result is never delivered. Post-reset contention grants Req0.

Source files
------------

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Shares one external combinational barrel shifter between two requesters.
// Requests are granted round-robin. The captured operand is presented to the
// shifter for one cycle (ISSUE). The direction-selected result is then
// registered and returned on the granted requester's response channel (RESP).
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid && ready are both high. Here ReqN_ready is combinational from
// the valids, so a source must hold valid and its payload until the transfer.
// RspN_valid/RspN_data stay stable until RspN_ready is seen.
//
// Ports:
//   Clk, Rst_n                 clock, async active-low reset
//   ReqN_valid/ready           request handshake (N = 0, 1)
//   ReqN_dir/amt/data          request payload (dir 1 = left, 0 = right)
//   RspN_valid/ready/data      response handshake and result
//   Sh_dir/amt/data            drive the shared shifter
//   Sh_left/Sh_right           shifter results (combinational from Sh_*)
//   Busy                       FSM not idle
//   Dbg_state                  raw FSM state for observation
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Req0_valid,
  output logic             Req0_ready,
  input  logic             Req0_dir,
  input  logic [AMT_W-1:0] Req0_amt,
  input  logic [WIDTH-1:0] Req0_data,
  input  logic             Req1_valid,
  output logic             Req1_ready,
  input  logic             Req1_dir,
  input  logic [AMT_W-1:0] Req1_amt,
  input  logic [WIDTH-1:0] Req1_data,
  output logic             Rsp0_valid,
  input  logic             Rsp0_ready,
  output logic [WIDTH-1:0] Rsp0_data,
  output logic             Rsp1_valid,
  input  logic             Rsp1_ready,
  output logic [WIDTH-1:0] Rsp1_data,
  output logic             Sh_dir,
  output logic [AMT_W-1:0] Sh_amt,
  output logic [WIDTH-1:0] Sh_data,
  input  logic [WIDTH-1:0] Sh_left,
  input  logic [WIDTH-1:0] Sh_right,
  output logic             Busy,
  output logic [1:0]       Dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_last_grant;
  logic               r_gnt;
  logic               r_dir;
  logic [AMT_W-1:0]   r_amt;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_result;

  logic               w_idle;
  logic               w_issue;
  logic               w_resp;
  logic               w_winner;
  logic               w_req_hs;
  logic               w_rsp_ready;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_issue = (r_state == ST_ISSUE);
  assign w_resp  = (r_state == ST_RESP);

  // Round-robin: on contention the requester not granted last time wins.
  always_comb begin
    w_winner = 1'b0;
    if (Req0_valid && Req1_valid) begin
      w_winner = ~r_last_grant;
    end else if (Req1_valid) begin
      w_winner = 1'b1;
    end
  end

  // Rst_n gates ready so nothing is offered while reset is held, even though
  // the state register already reads IDLE.
  assign Req0_ready = Rst_n & w_idle & Req0_valid & ~w_winner;
  assign Req1_ready = Rst_n & w_idle & Req1_valid &  w_winner;
  assign w_req_hs   = Req0_ready | Req1_ready;

  assign w_rsp_ready = r_gnt ? Rsp1_ready : Rsp0_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_req_hs) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_RESP;
      ST_RESP:  if (w_rsp_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_dir        <= 1'b0;
      r_amt        <= '0;
      r_data       <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_idle && w_req_hs) begin
        r_gnt        <= w_winner;
        r_last_grant <= w_winner;
        r_dir        <= w_winner ? Req1_dir  : Req0_dir;
        r_amt        <= w_winner ? Req1_amt  : Req0_amt;
        r_data       <= w_winner ? Req1_data : Req0_data;
      end
      if (w_issue) begin
        r_result <= r_dir ? Sh_left : Sh_right;
      end
    end
  end

  // r_dir only changes on capture, so driving Sh_dir from it directly keeps
  // the last direction outside ISSUE; amount/operand are parked at zero.
  assign Sh_dir  = r_dir;
  assign Sh_amt  = w_issue ? r_amt  : '0;
  assign Sh_data = w_issue ? r_data : '0;

  assign Rsp0_valid = w_resp & ~r_gnt;
  assign Rsp1_valid = w_resp &  r_gnt;
  assign Rsp0_data  = Rsp0_valid ? r_result : '0;
  assign Rsp1_data  = Rsp1_valid ? r_result : '0;

  assign Busy      = ~w_idle;
  assign Dbg_state = r_state;

endmodule
